// File: rtl/kl_isa_pkg.sv
// ISA constants and the decoded control bundle shared by the decode stage and its decoder.
// Opcode, sub-op, inst_type and used_RmRnRd bit positions live here so both files agree.
package kl_isa_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_BR  = 3'b010;
  localparam logic [2:0] OP_LDR = 3'b011;
  localparam logic [2:0] OP_STR = 3'b100;
  localparam logic [2:0] OP_ALU = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] BR_BX  = 2'b00;
  localparam logic [1:0] BR_RSV = 2'b01;
  localparam logic [1:0] BR_BLX = 2'b10;
  localparam logic [1:0] BR_BL  = 2'b11;

  localparam int IT_LDR = 0;
  localparam int IT_STR = 1;
  localparam int IT_BL  = 2;
  localparam int IT_BX  = 3;
  localparam int IT_BLX = 4;
  localparam int IT_RSV = 5;

  localparam int USE_RD = 0;
  localparam int USE_RN = 1;
  localparam int USE_RM = 2;

  // Field order matches the middle slice of control_out: {asel,bsel,loads,ALUop,shift,write}.
  typedef struct packed {
    logic       asel;
    logic       bsel;
    logic       loads;
    logic [1:0] alu_op;
    logic [1:0] shift;
    logic       write;
  } ctrl_t;

endpackage

// File: rtl/kl_decode_comb.sv
// Pure combinational instruction decoder: 16-bit IR -> control bundle, register indices,
// read-usage mask, one-hot instruction type and sign-extended immediate.
module kl_decode_comb
  import kl_isa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic [15:0]       ir,
  output ctrl_t             ctrl,
  output logic [REG_W-1:0]  writenum,
  output logic [REG_W-1:0]  num_rm,
  output logic [REG_W-1:0]  num_rn,
  output logic [REG_W-1:0]  num_rd,
  output logic [2:0]        used,
  output logic [5:0]        inst_type,
  output logic [DATA_W-1:0] sximm
);

  logic [1:0]        sub;
  logic [REG_W-1:0]  f_a;
  logic [REG_W-1:0]  f_d;
  logic [REG_W-1:0]  f_m;
  logic [DATA_W-1:0] imm8;
  logic [DATA_W-1:0] imm5;

  assign sub  = ir[12:11];
  assign f_a  = REG_W'(ir[10:8]);
  assign f_d  = REG_W'(ir[7:5]);
  assign f_m  = REG_W'(ir[2:0]);
  assign imm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign imm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl      = '0;
    writenum  = '0;
    used      = '0;
    inst_type = '0;
    sximm     = '0;
    num_rn    = f_a;
    num_rd    = f_d;
    num_rm    = f_m;
    case (ir[15:13])
      OP_NOP: ;
      OP_MOV: begin
        ctrl.asel  = 1'b1;
        ctrl.write = 1'b1;
        if (sub == MOV_IMM) begin
          ctrl.bsel = 1'b1;
          writenum  = f_a;
          sximm     = imm8;
        end else begin
          ctrl.shift   = ir[4:3];
          writenum     = f_d;
          used[USE_RM] = 1'b1;
        end
      end
      OP_ALU: begin
        ctrl.alu_op  = sub;
        ctrl.shift   = ir[4:3];
        used[USE_RM] = 1'b1;
        case (sub)
          ALU_CMP: begin
            ctrl.loads   = 1'b1;
            used[USE_RN] = 1'b1;
          end
          ALU_MVN: begin
            ctrl.write = 1'b1;
            writenum   = f_d;
          end
          ALU_ADD, ALU_AND: begin
            ctrl.write   = 1'b1;
            writenum     = f_d;
            used[USE_RN] = 1'b1;
          end
          default: ;
        endcase
      end
      OP_STR: begin
        num_rm            = f_a;
        ctrl.bsel         = 1'b1;
        sximm             = imm5;
        used[USE_RM]      = 1'b1;
        used[USE_RD]      = 1'b1;
        inst_type[IT_STR] = 1'b1;
      end
      OP_LDR: begin
        num_rm            = f_a;
        ctrl.bsel         = 1'b1;
        ctrl.write        = 1'b1;
        writenum          = f_d;
        sximm             = imm5;
        used[USE_RM]      = 1'b1;
        inst_type[IT_LDR] = 1'b1;
      end
      OP_BR: begin
        // Link-writing branches put the link register in the IR[10:8] field.
        case (sub)
          BR_BL: begin
            ctrl.write       = 1'b1;
            writenum         = f_a;
            sximm            = imm8;
            inst_type[IT_BL] = 1'b1;
          end
          BR_BX: begin
            used[USE_RD]     = 1'b1;
            inst_type[IT_BX] = 1'b1;
          end
          BR_BLX: begin
            ctrl.write        = 1'b1;
            writenum          = f_a;
            used[USE_RD]      = 1'b1;
            inst_type[IT_BLX] = 1'b1;
          end
          BR_RSV:  inst_type[IT_RSV] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage_reg.sv
// Registered decode stage: valid/ready handshake, one output register slot and a
// per-register countdown scoreboard that stalls reads of in-flight writes.
module decode_stage_reg
  import kl_isa_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int PC_W     = 8,
  parameter int REG_W    = 3,
  parameter int WB_LAT   = 3,
  parameter int LD_EXTRA = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            IR_in,
  input  logic [PC_W-1:0]        PC,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W+REG_W+10:0] control_out,
  output logic [REG_W-1:0]       num_Rm,
  output logic [REG_W-1:0]       num_Rn,
  output logic [REG_W-1:0]       num_Rd,
  output logic [2:0]             used_RmRnRd,
  output logic [5:0]             inst_type,
  output logic [DATA_W-1:0]      sximm,
  output logic                   hazard_stall
);

  localparam int NREG  = 2 ** REG_W;
  localparam int CNT_W = $clog2(WB_LAT + LD_EXTRA + 1);
  localparam logic [CNT_W-1:0] LAT_ALU = CNT_W'(WB_LAT);
  localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(WB_LAT + LD_EXTRA);

  ctrl_t             d_ctrl;
  logic [REG_W-1:0]  d_writenum;
  logic [REG_W-1:0]  d_rm;
  logic [REG_W-1:0]  d_rn;
  logic [REG_W-1:0]  d_rd;
  logic [2:0]        d_used;
  logic [5:0]        d_inst_type;
  logic [DATA_W-1:0] d_sximm;

  logic [CNT_W-1:0]  cnt [NREG];
  logic [2:0]        busy;
  logic              hazard;
  logic              accept;

  kl_decode_comb #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_decode (
    .ir        (IR_in),
    .ctrl      (d_ctrl),
    .writenum  (d_writenum),
    .num_rm    (d_rm),
    .num_rn    (d_rn),
    .num_rd    (d_rd),
    .used      (d_used),
    .inst_type (d_inst_type),
    .sximm     (d_sximm)
  );

  assign busy[USE_RM] = cnt[d_rm] != '0;
  assign busy[USE_RN] = cnt[d_rn] != '0;
  assign busy[USE_RD] = cnt[d_rd] != '0;
  assign hazard       = in_valid & |(d_used & busy);
  assign hazard_stall = hazard & ~flush;

  // rst_n gates acceptance so a fetch held across reset is not consumed while in reset.
  assign in_ready = rst_n & (~out_valid | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      out_valid   <= 1'b0;
      control_out <= '0;
      num_Rm      <= '0;
      num_Rn      <= '0;
      num_Rd      <= '0;
      used_RmRnRd <= '0;
      inst_type   <= '0;
      sximm       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      control_out <= {IR_in[15:13], PC, d_ctrl, d_writenum};
      num_Rm      <= d_rm;
      num_Rn      <= d_rn;
      num_Rd      <= d_rd;
      used_RmRnRd <= d_used;
      inst_type   <= d_inst_type;
      sximm       <= d_sximm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the counter array is reset explicitly; it gates issue, so unknown contents would stall or leak hazards.
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (flush)
          cnt[i] <= '0;
        else if (accept && d_ctrl.write && d_writenum == REG_W'(i))
          cnt[i] <= d_inst_type[IT_LDR] ? LAT_LD : LAT_ALU;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_reg.sv
// Self-checking bench for decode_stage_reg: directed scenarios plus a randomized run
// against a mnemonic-level decoder and a timestamp-based write-readiness model.
module tb_decode_stage_reg;

  localparam int DATA_W   = 16;
  localparam int PC_W     = 8;
  localparam int REG_W    = 3;
  localparam int WB_LAT   = 3;
  localparam int LD_EXTRA = 1;

  typedef enum {K_NONE, K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN,
                K_STR, K_LDR, K_BL, K_BX, K_BLX, K_RSV} kind_e;

  // Same bit order as {control_out, num_Rm, num_Rn, num_Rd, used_RmRnRd, inst_type, sximm}.
  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  pc;
    logic        asel;
    logic        bsel;
    logic        loads;
    logic [1:0]  alu;
    logic [1:0]  sh;
    logic        wr;
    logic [2:0]  wn;
    logic [2:0]  rm;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  used;
    logic [5:0]  itype;
    logic [15:0] sximm;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] control_out;
  logic [2:0]  num_Rm;
  logic [2:0]  num_Rn;
  logic [2:0]  num_Rd;
  logic [2:0]  used_RmRnRd;
  logic [5:0]  inst_type;
  logic [15:0] sximm;
  logic        hazard_stall;
  dec_t        obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign obs = {control_out, num_Rm, num_Rn, num_Rd, used_RmRnRd, inst_type, sximm};

  decode_stage_reg #(
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .REG_W    (REG_W),
    .WB_LAT   (WB_LAT),
    .LD_EXTRA (LD_EXTRA)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .IR_in        (ir),
    .PC           (pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .control_out  (control_out),
    .num_Rm       (num_Rm),
    .num_Rn       (num_Rn),
    .num_Rd       (num_Rd),
    .used_RmRnRd  (used_RmRnRd),
    .inst_type    (inst_type),
    .sximm        (sximm),
    .hazard_stall (hazard_stall)
  );

  function automatic dec_t ref_decode(input logic [15:0] i, input logic [7:0] p);
    dec_t        r;
    kind_e       k;
    logic [15:0] imm8;
    logic [15:0] imm5;
    imm8 = {{8{i[7]}}, i[7:0]};
    imm5 = {{11{i[4]}}, i[4:0]};
    case (i[15:13])
      3'b110:  k = (i[12:11] == 2'b10) ? K_MOVI : K_MOVR;
      3'b101:  case (i[12:11])
                 2'b00:   k = K_ADD;
                 2'b01:   k = K_CMP;
                 2'b10:   k = K_AND;
                 default: k = K_MVN;
               endcase
      3'b100:  k = K_STR;
      3'b011:  k = K_LDR;
      3'b010:  case (i[12:11])
                 2'b11:   k = K_BL;
                 2'b00:   k = K_BX;
                 2'b10:   k = K_BLX;
                 default: k = K_RSV;
               endcase
      default: k = K_NONE;
    endcase
    r    = '0;
    r.op = i[15:13];
    r.pc = p;
    r.rn = i[10:8];
    r.rd = i[7:5];
    r.rm = (k == K_LDR || k == K_STR) ? i[10:8] : i[2:0];
    case (k)
      K_MOVI:       begin r.asel = 1; r.bsel = 1; r.wr = 1; r.wn = i[10:8]; r.sximm = imm8; end
      K_MOVR:       begin r.asel = 1; r.sh = i[4:3]; r.wr = 1; r.wn = i[7:5]; r.used = 3'b100; end
      K_ADD, K_AND: begin r.alu = i[12:11]; r.sh = i[4:3]; r.wr = 1; r.wn = i[7:5]; r.used = 3'b110; end
      K_CMP:        begin r.alu = 2'b01; r.sh = i[4:3]; r.loads = 1; r.used = 3'b110; end
      K_MVN:        begin r.alu = 2'b11; r.sh = i[4:3]; r.wr = 1; r.wn = i[7:5]; r.used = 3'b100; end
      K_STR:        begin r.bsel = 1; r.sximm = imm5; r.used = 3'b101; r.itype = 6'b000010; end
      K_LDR:        begin r.bsel = 1; r.sximm = imm5; r.wr = 1; r.wn = i[7:5]; r.used = 3'b100; r.itype = 6'b000001; end
      K_BL:         begin r.wr = 1; r.wn = i[10:8]; r.sximm = imm8; r.itype = 6'b000100; end
      K_BX:         begin r.used = 3'b001; r.itype = 6'b001000; end
      K_BLX:        begin r.wr = 1; r.wn = i[10:8]; r.used = 3'b001; r.itype = 6'b010000; end
      K_RSV:        r.itype = 6'b100000;
      default:      ;
    endcase
    return r;
  endfunction

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; ir = 16'h0000; pc = 8'h00; out_ready = 1'b1; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", hazard_stall); end
  endtask

  task automatic test_mov_imm();
    @(negedge clk);
    in_valid = 1'b1; ir = 16'hD105; pc = 8'h10; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mov_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mov_out_valid: got %b want 1", out_valid); end
    checks++; if ({obs.wr, obs.wn, obs.asel, obs.bsel} !== 6'b1_001_11)
      begin errors++; $display("FAIL mov_fields: got %b want 100111", {obs.wr, obs.wn, obs.asel, obs.bsel}); end
    checks++; if (sximm !== 16'h0005) begin errors++; $display("FAIL mov_sximm: got %h want 0005", sximm); end
    checks++; if (obs !== ref_decode(16'hD105, 8'h10))
      begin errors++; $display("FAIL mov_decode: got %h want %h", obs, ref_decode(16'hD105, 8'h10)); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mov_valid_clear: got %b want 0", out_valid); end
  endtask

  task automatic test_raw_stall(input logic [15:0] writer, input int exp_stall, input string name);
    int n;
    bit got;
    drain();
    @(negedge clk);
    in_valid = 1'b1; ir = writer; pc = 8'h20;
    @(negedge clk);
    ir = 16'hA140; pc = 8'h21; n = 0; got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (in_ready) begin got = 1'b1; break; end
      if (hazard_stall) n++;
      @(negedge clk);
    end
    checks++; if (!got || n != exp_stall)
      begin errors++; $display("FAIL %s_stall_cycles: got %0d (accepted=%0b) want %0d", name, n, got, exp_stall); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || obs !== ref_decode(16'hA140, 8'h21))
      begin errors++; $display("FAIL %s_add_out: got v=%b %h want %h", name, out_valid, obs, ref_decode(16'hA140, 8'h21)); end
  endtask

  task automatic test_backpressure();
    drain();
    @(negedge clk);
    in_valid = 1'b1; ir = 16'hA900; pc = 8'h30; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", in_ready); end
    @(negedge clk);
    ir = 16'hD307; pc = 8'h31;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || hazard_stall !== 1'b0)
        begin errors++; $display("FAIL bp_blocked: got ready=%b stall=%b want 0 0", in_ready, hazard_stall); end
      checks++; if (out_valid !== 1'b1 || obs !== ref_decode(16'hA900, 8'h30))
        begin errors++; $display("FAIL bp_hold: got v=%b %h want %h", out_valid, obs, ref_decode(16'hA900, 8'h30)); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || obs !== ref_decode(16'hD307, 8'h31))
      begin errors++; $display("FAIL bp_second_out: got v=%b %h want %h", out_valid, obs, ref_decode(16'hD307, 8'h31)); end
  endtask

  task automatic test_flush();
    drain();
    @(negedge clk);
    in_valid = 1'b1; ir = 16'hD105; pc = 8'h40;
    @(negedge clk);
    ir = 16'hA140; pc = 8'h41;
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %b want 1", hazard_stall); end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || hazard_stall !== 1'b0)
      begin errors++; $display("FAIL flush_cycle: got ready=%b stall=%b want 0 0", in_ready, hazard_stall); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1 || hazard_stall !== 1'b0)
      begin errors++; $display("FAIL flush_counters: got ready=%b stall=%b want 1 0", in_ready, hazard_stall); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || obs !== ref_decode(16'hA140, 8'h41))
      begin errors++; $display("FAIL flush_add_out: got v=%b %h want %h", out_valid, obs, ref_decode(16'hA140, 8'h41)); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    @(negedge clk);
    in_valid = 1'b1; ir = 16'hD105; pc = 8'h50;
    @(negedge clk);
    ir = 16'hA140; pc = 8'h51;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || obs !== '0)
      begin errors++; $display("FAIL rst_stall_state: got v=%b %h want 0", out_valid, obs); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_stall_release: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || obs !== ref_decode(16'hA140, 8'h51))
      begin errors++; $display("FAIL rst_stall_add: got v=%b %h want %h", out_valid, obs, ref_decode(16'hA140, 8'h51)); end
  endtask

  task automatic test_back_to_back_sximm();
    logic [15:0] seq [3];
    logic [15:0] want_sx [3];
    seq     = '{16'hD2FF, 16'h6030, 16'hE123};
    want_sx = '{16'hFFFF, 16'hFFF0, 16'h0000};
    drain();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = (i < 3);
      if (i < 3) begin ir = seq[i]; pc = 8'(8'h60 + i); end
      #1;
      if (i < 3) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready); end
      end
      if (i > 0) begin
        checks++; if (sximm !== want_sx[i-1]) begin errors++; $display("FAIL b2b_sximm_%0d: got %h want %h", i - 1, sximm, want_sx[i-1]); end
        checks++; if (out_valid !== 1'b1 || obs !== ref_decode(seq[i-1], 8'(8'h60 + i - 1)))
          begin errors++; $display("FAIL b2b_decode_%0d: got v=%b %h want %h", i - 1, out_valid, obs, ref_decode(seq[i-1], 8'(8'h60 + i - 1))); end
      end
    end
    checks++; if (obs.wr !== 1'b0 || inst_type !== 6'b0)
      begin errors++; $display("FAIL op111_controls: got write=%b type=%b want 0 0", obs.wr, inst_type); end
  endtask

  task automatic test_random();
    dec_t d;
    dec_t m_out;
    bit   m_valid;
    bit   hold;
    bit   haz;
    bit   rdy;
    bit   acc;
    int   t;
    int   ready_at [8];
    drain();
    m_valid = 1'b0; m_out = '0; hold = 1'b0; t = 0;
    foreach (ready_at[j]) ready_at[j] = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (!hold) begin
        in_valid = ($urandom_range(3) != 0);
        ir       = 16'($urandom);
        pc       = 8'($urandom);
      end
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(15) == 0);
      #1;
      d   = ref_decode(ir, pc);
      haz = in_valid && ((d.used[2] && t < ready_at[d.rm]) ||
                         (d.used[1] && t < ready_at[d.rn]) ||
                         (d.used[0] && t < ready_at[d.rd]));
      rdy = (!m_valid || out_ready) && !haz && !flush;
      acc = in_valid && rdy;
      checks++; if (in_ready !== rdy) begin errors++; $display("FAIL rnd_in_ready c=%0d ir=%h: got %b want %b", c, ir, in_ready, rdy); end
      checks++; if (hazard_stall !== (haz && !flush))
        begin errors++; $display("FAIL rnd_hazard c=%0d ir=%h: got %b want %b", c, ir, hazard_stall, haz && !flush); end
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_out_valid c=%0d: got %b want %b", c, out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (obs !== m_out) begin errors++; $display("FAIL rnd_outputs c=%0d: got %h want %h", c, obs, m_out); end
      end
      if (flush) begin
        m_valid = 1'b0;
        foreach (ready_at[j]) ready_at[j] = 0;
      end else if (acc) begin
        m_valid = 1'b1;
        m_out   = d;
        if (d.wr) ready_at[d.wn] = t + 1 + (d.itype[0] ? WB_LAT + LD_EXTRA : WB_LAT);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      hold = in_valid && !acc && !flush;
      @(posedge clk);
      t++;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mov_imm();
    test_raw_stall(16'hD105, WB_LAT, "mov_writer");
    test_raw_stall(16'h6020, WB_LAT + LD_EXTRA, "ldr_writer");
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back_sximm();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
